seq_detect_prog: RTL and testbench

//  Runtime-programmable serial sequence detector: next generation of the fixed-pattern detector.

---
 rtl/seq_detect_prog.sv | 96 +++++++++
 tb/tb_seq_detect_prog.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial sequence detector with Mealy match flag,
// overlap/restart modes, enable gating and a saturating match counter.
module seq_detect_prog #(
    parameter int unsigned MAX_LEN     = 8,
    parameter int unsigned CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PAT = 'h09,
    parameter int unsigned DEFAULT_LEN = 4,
    parameter int unsigned LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               sysClk,
    input  logic               resetH,
    input  logic               enableH,
    input  logic               loadH,
    input  logic [MAX_LEN-1:0] patIn,
    input  logic [LEN_W-1:0]   lenIn,
    input  logic               overlapH,
    input  logic               clrCntH,
    input  logic               sigA,
    output logic               outAH,
    output logic [CNT_W-1:0]   matchCnt
);

    localparam int unsigned HIST_W = MAX_LEN - 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] FILL_MAX  = LEN_W'(MAX_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    logic [HIST_W-1:0]  hist;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] lenMask;
    logic [LEN_W-1:0]   lenClamped;
    logic               windowHit;
    logic               fillOk;

    // Newest bit joins the history; only the low len bits take part in the compare.
    always_comb begin
        window  = {hist, sigA};
        lenMask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            lenMask[i] = (LEN_W'(i) < len);
        end
        windowHit  = ((window ^ pat) & lenMask) == '0;
        fillOk     = (len != '0) && (fill >= (len - LEN_W'(1)));
        outAH      = !resetH && enableH && !loadH && fillOk && windowHit;
        lenClamped = (lenIn > MAX_LEN_L) ? MAX_LEN_L : lenIn;
    end

    // Pattern configuration
    always_ff @(posedge sysClk or posedge resetH) begin
        if (resetH) begin
            pat     <= DEFAULT_PAT;
            len     <= LEN_W'(DEFAULT_LEN);
            overlap <= 1'b1;
        end else if (loadH) begin
            pat     <= patIn;
            len     <= lenClamped;
            overlap <= overlapH;
        end
    end

    // History shift register and valid-bit count; restart mode drops matched bits
    always_ff @(posedge sysClk or posedge resetH) begin
        if (resetH) begin
            hist <= '0;
            fill <= '0;
        end else if (loadH) begin
            hist <= '0;
            fill <= '0;
        end else if (enableH) begin
            if (outAH && !overlap) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= window[HIST_W-1:0];
                fill <= (fill == FILL_MAX) ? fill : fill + LEN_W'(1);
            end
        end
    end

    // Saturating match counter; clear wins over increment
    always_ff @(posedge sysClk or posedge resetH) begin
        if (resetH) begin
            matchCnt <= '0;
        end else if (loadH || clrCntH) begin
            matchCnt <= '0;
        end else if (outAH && (matchCnt != CNT_MAX)) begin
            matchCnt <= matchCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: expected match flags are queued as bits are
// driven and popped when the flag is sampled; matchCnt is tracked by a small model.
module tb_seq_detect_prog;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned LEN_W   = 4;

    logic               sysClk_tb;
    logic               resetH;
    logic               enableH;
    logic               loadH;
    logic [MAX_LEN-1:0] patIn;
    logic [LEN_W-1:0]   lenIn;
    logic               overlapH;
    logic               clrCntH;
    logic               sigA;
    logic               outAH;
    logic [CNT_W-1:0]   matchCnt;

    int   vecCnt = 0;
    int   errCnt = 0;
    logic expQ[$];
    int   expCnt = 0;

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .sysClk   (sysClk_tb),
        .resetH   (resetH),
        .enableH  (enableH),
        .loadH    (loadH),
        .patIn    (patIn),
        .lenIn    (lenIn),
        .overlapH (overlapH),
        .clrCntH  (clrCntH),
        .sigA     (sigA),
        .outAH    (outAH),
        .matchCnt (matchCnt)
    );

    initial begin
        sysClk_tb = 1'b0;
        forever #5 sysClk_tb = ~sysClk_tb;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic step(input string tag, input logic b, input logic en, input logic clr,
                        input logic expOut);
        logic e;
        sigA    = b;
        enableH = en;
        clrCntH = clr;
        expQ.push_back(expOut);
        #2;
        e = expQ.pop_front();
        check({tag, ".outAH"}, 32'(outAH), 32'(e));
        @(posedge sysClk_tb);
        #1;
        if (clr) expCnt = 0;
        else if (e && expCnt < 3) expCnt++;
        check({tag, ".matchCnt"}, 32'(matchCnt), 32'(expCnt));
        clrCntH = 1'b0;
    endtask

    task automatic doReset();
        resetH = 1'b1;
        @(posedge sysClk_tb);
        #1;
        resetH = 1'b0;
        expCnt = 0;
    endtask

    task automatic doLoad(input string tag, input logic [7:0] p, input logic [3:0] l,
                          input logic ov);
        loadH    = 1'b1;
        patIn    = p;
        lenIn    = l;
        overlapH = ov;
        enableH  = 1'b1;
        sigA     = 1'b1;
        #2;
        check({tag, ".loadOutAH"}, 32'(outAH), 32'd0);
        @(posedge sysClk_tb);
        #1;
        loadH  = 1'b0;
        expCnt = 0;
        check({tag, ".loadCnt"}, 32'(matchCnt), 32'd0);
    endtask

    task automatic runStream(input string tag, input logic [15:0] bits,
                             input logic [15:0] exps, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(tag, bits[i], 1'b1, 1'b0, exps[i]);
        end
    endtask

    initial begin
        resetH = 1'b1; enableH = 1'b0; loadH = 1'b0; patIn = '0; lenIn = '0;
        overlapH = 1'b0; clrCntH = 1'b0; sigA = 1'b1;
        #2;
        check("reset.outAH", 32'(outAH), 32'd0);
        check("reset.matchCnt", 32'(matchCnt), 32'd0);
        @(posedge sysClk_tb);
        #1;
        resetH = 1'b0;

        // Default 1001 pattern, single match on bit 7
        runStream("t1", 16'b0001001, 16'b0000001, 7);

        // Overlap: matches on bits 4 and 7; restart mode only on bit 4
        doReset();
        runStream("t2ov", 16'b1001001, 16'b0001001, 7);
        doLoad("t2ld", 8'h09, 4'd4, 1'b0);
        runStream("t2nov", 16'b1001001, 16'b0001000, 7);

        // Length 6, length 0 (disabled), length 15 clamped to 8
        doLoad("t3ld6", 8'b00110101, 4'd6, 1'b1);
        runStream("t3len6", 16'b110101, 16'b000001, 6);
        doLoad("t3ld0", 8'b00000001, 4'd0, 1'b1);
        runStream("t3len0", 16'b1001101011, 16'b0000000000, 10);
        doLoad("t3ld15", 8'b10110011, 4'd15, 1'b1);
        runStream("t3len8", 16'b10110011, 16'b00000001, 8);

        // Enable gap ignored: 1,0 / gap 1,0,1 / 0,1
        doReset();
        step("t4a", 1'b1, 1'b1, 1'b0, 1'b0);
        step("t4b", 1'b0, 1'b1, 1'b0, 1'b0);
        step("t4g1", 1'b1, 1'b0, 1'b0, 1'b0);
        step("t4g2", 1'b0, 1'b0, 1'b0, 1'b0);
        step("t4g3", 1'b1, 1'b0, 1'b0, 1'b0);
        step("t4c", 1'b0, 1'b1, 1'b0, 1'b0);
        step("t4d", 1'b1, 1'b1, 1'b0, 1'b1);

        // Five overlapping matches saturate a 2-bit counter; clear beats a match
        doReset();
        runStream("t5sat", 16'b1001001001001001, 16'b0001001001001001, 16);
        step("t5c0", 1'b0, 1'b1, 1'b0, 1'b0);
        step("t5c1", 1'b0, 1'b1, 1'b0, 1'b0);
        step("t5clr", 1'b1, 1'b1, 1'b1, 1'b1);

        // Async reset mid-pattern
        doReset();
        runStream("t6pre", 16'b100, 16'b000, 3);
        sigA = 1'b1; enableH = 1'b1;
        #2;
        check("t6.armed", 32'(outAH), 32'd1);
        resetH = 1'b1;
        #1;
        check("t6.rstOutAH", 32'(outAH), 32'd0);
        check("t6.rstCnt", 32'(matchCnt), 32'd0);
        @(posedge sysClk_tb);
        #1;
        resetH = 1'b0;
        expCnt = 0;
        step("t6lone", 1'b1, 1'b1, 1'b0, 1'b0);
        runStream("t6full", 16'b001, 16'b001, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
